// File: rtl/call_stack_unit.sv
// Hardware return/data stack for the 8-bit RISC core: call/ret/push/pop with
// interrupt entry, a one-deep pending-interrupt latch and sticky error flags.
module call_stack_unit #(
    parameter int             DW      = 8,
    parameter int             DEPTH   = 8,
    parameter logic [DW-1:0]  IRQ_VEC = DW'(8'hF0),
    localparam int            AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          eint,
    input  logic          call,
    input  logic          ret,
    input  logic          push,
    input  logic          pop,
    input  logic          clr_err,
    input  logic [DW-1:0] pc_in,
    input  logic [DW-1:0] target,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] pc_out,
    output logic          pc_load,
    output logic [DW-1:0] data_out,
    output logic [DW-1:0] top,
    output logic [DW-1:0] lnk,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          unf,
    output logic          in_isr
);

    logic [DW-1:0] mem [DEPTH];
    logic          pend;
    logic [AW:0]   isr_depth;

    logic          irq_req, irq_take, op_en, pp_en;
    logic          do_call, do_ret, do_push, do_pop, do_repl;
    logic          ovf_set, unf_set, wr_en;
    logic [AW-1:0] top_idx, wr_idx;
    logic [DW-1:0] wr_data;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign top_idx = AW'(count - 1'b1);
    assign top     = empty ? '0 : mem[top_idx];

    // An interrupt that cannot be entered (already in ISR, or stack full) only
    // latches pend; the lower-priority op still runs so a full stack can drain.
    always_comb begin
        irq_req  = eint | pend;
        irq_take = irq_req & ~in_isr & ~full;
        op_en    = ~irq_take;
        do_call  = op_en & call;
        do_ret   = op_en & ~call & ret;
        pp_en    = op_en & ~call & ~ret;
        do_repl  = pp_en & push & pop & ~empty;
        do_push  = pp_en & push & ~(pop & ~empty);
        do_pop   = pp_en & pop & ~push;
        ovf_set  = (irq_req & ~in_isr & full) | (do_call & full) | (do_push & full);
        unf_set  = (do_ret & empty) | (do_pop & empty);
        wr_en    = ((irq_take | do_call | do_push) & ~full) | do_repl;
        wr_idx   = do_repl ? top_idx : AW'(count);
        wr_data  = (irq_take | do_call) ? pc_in : data_in;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out    <= '0;
            pc_load   <= 1'b0;
            data_out  <= '0;
            lnk       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            in_isr    <= 1'b0;
            pend      <= 1'b0;
            isr_depth <= '0;
        end else begin
            pc_load <= 1'b0;
            if (irq_req)
                pend <= ~irq_take;
            if (irq_take) begin
                count     <= count + 1'b1;
                pc_out    <= IRQ_VEC;
                pc_load   <= 1'b1;
                lnk       <= pc_in;
                in_isr    <= 1'b1;
                isr_depth <= count;
            end
            if (do_call && !full) begin
                count   <= count + 1'b1;
                pc_out  <= target;
                pc_load <= 1'b1;
                lnk     <= pc_in;
            end
            if (do_ret && !empty) begin
                pc_out  <= top;
                pc_load <= 1'b1;
                count   <= count - 1'b1;
                if (in_isr && count == isr_depth + 1'b1)
                    in_isr <= 1'b0;
            end
            if (do_push && !full)
                count <= count + 1'b1;
            if (do_repl)
                data_out <= top;
            if (do_pop && !empty) begin
                data_out <= top;
                count    <= count - 1'b1;
            end
            ovf <= ovf_set | (ovf & ~clr_err);
            unf <= unf_set | (unf & ~clr_err);
        end
    end

endmodule

// File: tb/tb_call_stack_unit.sv
// Bench for call_stack_unit (DW=8, DEPTH=4): directed vector table, async reset
// sequence, then random traffic against a queue-based stack model.
module tb_call_stack_unit;

    localparam int            DEPTH   = 4;
    localparam logic [7:0]    IRQ_VEC = 8'hF0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       eint = 1'b0, call = 1'b0, ret = 1'b0, push = 1'b0, pop = 1'b0, clr_err = 1'b0;
    logic [7:0] pc_in = '0, target = '0, data_in = '0;
    logic [7:0] pc_out, data_out, top, lnk;
    logic       pc_load, full, empty, ovf, unf, in_isr;
    logic [2:0] count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    call_stack_unit #(.DW(8), .DEPTH(DEPTH), .IRQ_VEC(IRQ_VEC)) dut (
        .clk(clk), .rst(rst), .eint(eint), .call(call), .ret(ret), .push(push),
        .pop(pop), .clr_err(clr_err), .pc_in(pc_in), .target(target),
        .data_in(data_in), .pc_out(pc_out), .pc_load(pc_load), .data_out(data_out),
        .top(top), .lnk(lnk), .count(count), .full(full), .empty(empty),
        .ovf(ovf), .unf(unf), .in_isr(in_isr)
    );

    // Behavioural model: the stack is a queue, back = top of stack.
    logic [7:0] mq[$];
    logic [7:0] m_pc_out, m_data_out, m_lnk;
    logic       m_pc_load, m_ovf, m_unf, m_in_isr, m_pend;
    int         m_isr_depth;

    task automatic model_reset;
        mq.delete();
        m_pc_out = '0; m_data_out = '0; m_lnk = '0;
        m_pc_load = 0; m_ovf = 0; m_unf = 0; m_in_isr = 0; m_pend = 0; m_isr_depth = 0;
    endtask

    task automatic model_step;
        int   n;
        logic took, ovf_s, unf_s;
        n = mq.size();
        took = 0; ovf_s = 0; unf_s = 0; m_pc_load = 0;
        if (eint || m_pend) begin
            if (!m_in_isr && n < DEPTH) begin
                mq.push_back(pc_in);
                m_pc_out = IRQ_VEC; m_pc_load = 1; m_lnk = pc_in;
                m_isr_depth = n; m_in_isr = 1; m_pend = 0; took = 1;
            end else begin
                m_pend = 1;
                if (!m_in_isr) ovf_s = 1;
            end
        end
        if (!took) begin
            if (call) begin
                if (n < DEPTH) begin
                    mq.push_back(pc_in);
                    m_pc_out = target; m_pc_load = 1; m_lnk = pc_in;
                end else ovf_s = 1;
            end else if (ret) begin
                if (n > 0) begin
                    m_pc_out = mq.pop_back(); m_pc_load = 1;
                    if (m_in_isr && n == m_isr_depth + 1) m_in_isr = 0;
                end else unf_s = 1;
            end else if (push && pop && n > 0) begin
                m_data_out = mq[n-1];
                mq[n-1] = data_in;
            end else if (push) begin
                if (n < DEPTH) mq.push_back(data_in); else ovf_s = 1;
            end else if (pop) begin
                if (n > 0) m_data_out = mq.pop_back(); else unf_s = 1;
            end
        end
        m_ovf = ovf_s | (m_ovf & ~clr_err);
        m_unf = unf_s | (m_unf & ~clr_err);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [5:0] ctl, input logic [7:0] pc, input logic [7:0] tg,
                         input logic [7:0] di);
        {eint, call, ret, push, pop, clr_err} = ctl;
        pc_in = pc; target = tg; data_in = di;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic cmp_model;
        logic [7:0] mtop;
        mtop = (mq.size() > 0) ? mq[mq.size()-1] : 8'h00;
        chk("rnd pc_load", pc_load, m_pc_load);
        chk("rnd pc_out", pc_out, m_pc_out);
        chk("rnd data_out", data_out, m_data_out);
        chk("rnd top", top, mtop);
        chk("rnd lnk", lnk, m_lnk);
        chk("rnd count", count, mq.size());
        chk("rnd full", full, mq.size() == DEPTH);
        chk("rnd empty", empty, mq.size() == 0);
        chk("rnd ovf", ovf, m_ovf);
        chk("rnd unf", unf, m_unf);
        chk("rnd in_isr", in_isr, m_in_isr);
    endtask

    task automatic do_reset;
        {eint, call, ret, push, pop, clr_err} = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [5:0] ctl;      // {eint, call, ret, push, pop, clr_err}
        logic [7:0] pc, tg, di;
        logic       x_ld;
        logic [7:0] x_pc, x_do, x_top;
        logic [2:0] x_cnt;
        logic [2:0] x_flg;    // {ovf, unf, in_isr}
        logic [7:0] x_lnk;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [5:0] ctl, input logic [7:0] pc, input logic [7:0] tg,
                                input logic [7:0] di, input logic ld, input logic [7:0] xpc,
                                input logic [7:0] xdo, input logic [7:0] xtop,
                                input logic [2:0] cnt, input logic [2:0] flg,
                                input logic [7:0] xlnk);
        vec_t v;
        v.ctl = ctl; v.pc = pc; v.tg = tg; v.di = di; v.x_ld = ld; v.x_pc = xpc;
        v.x_do = xdo; v.x_top = xtop; v.x_cnt = cnt; v.x_flg = flg; v.x_lnk = xlnk;
        return v;
    endfunction

    initial begin
        model_reset();
        #1;
        chk("rst pc_load", pc_load, 0);
        chk("rst pc_out", pc_out, 0);
        chk("rst data_out", data_out, 0);
        chk("rst count", count, 0);
        chk("rst empty", empty, 1);
        chk("rst in_isr", in_isr, 0);
        chk("rst ovf", ovf, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        //              ctl        pc     tg     di    ld  pc_out do     top    cnt  flg     lnk
        tbl.push_back(mk(6'b000100, 8'h00, 8'h00, 8'h11, 0, 8'h00, 8'h00, 8'h11, 1, 3'b000, 8'h00));
        tbl.push_back(mk(6'b000100, 8'h00, 8'h00, 8'h22, 0, 8'h00, 8'h00, 8'h22, 2, 3'b000, 8'h00));
        tbl.push_back(mk(6'b000100, 8'h00, 8'h00, 8'h33, 0, 8'h00, 8'h00, 8'h33, 3, 3'b000, 8'h00));
        tbl.push_back(mk(6'b000100, 8'h00, 8'h00, 8'h44, 0, 8'h00, 8'h00, 8'h44, 4, 3'b000, 8'h00));
        tbl.push_back(mk(6'b000100, 8'h00, 8'h00, 8'h55, 0, 8'h00, 8'h00, 8'h44, 4, 3'b100, 8'h00));
        tbl.push_back(mk(6'b000010, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h44, 8'h33, 3, 3'b100, 8'h00));
        tbl.push_back(mk(6'b000010, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h33, 8'h22, 2, 3'b100, 8'h00));
        tbl.push_back(mk(6'b000010, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h22, 8'h11, 1, 3'b100, 8'h00));
        tbl.push_back(mk(6'b000010, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h11, 8'h00, 0, 3'b100, 8'h00));
        tbl.push_back(mk(6'b000010, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h11, 8'h00, 0, 3'b110, 8'h00));
        tbl.push_back(mk(6'b000001, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h11, 8'h00, 0, 3'b000, 8'h00));
        tbl.push_back(mk(6'b010000, 8'h10, 8'h40, 8'h00, 1, 8'h40, 8'h11, 8'h10, 1, 3'b000, 8'h10));
        tbl.push_back(mk(6'b000000, 8'h00, 8'h00, 8'h00, 0, 8'h40, 8'h11, 8'h10, 1, 3'b000, 8'h10));
        tbl.push_back(mk(6'b001000, 8'h00, 8'h00, 8'h00, 1, 8'h10, 8'h11, 8'h00, 0, 3'b000, 8'h10));
        tbl.push_back(mk(6'b000000, 8'h00, 8'h00, 8'h00, 0, 8'h10, 8'h11, 8'h00, 0, 3'b000, 8'h10));
        tbl.push_back(mk(6'b000100, 8'h00, 8'h00, 8'h07, 0, 8'h10, 8'h11, 8'h07, 1, 3'b000, 8'h10));
        tbl.push_back(mk(6'b100000, 8'h21, 8'h00, 8'h00, 1, 8'hF0, 8'h11, 8'h21, 2, 3'b001, 8'h21));
        tbl.push_back(mk(6'b100000, 8'h22, 8'h00, 8'h00, 0, 8'hF0, 8'h11, 8'h21, 2, 3'b001, 8'h21));
        tbl.push_back(mk(6'b001000, 8'h00, 8'h00, 8'h00, 1, 8'h21, 8'h11, 8'h07, 1, 3'b000, 8'h21));
        tbl.push_back(mk(6'b000000, 8'h30, 8'h00, 8'h00, 1, 8'hF0, 8'h11, 8'h30, 2, 3'b001, 8'h30));
        tbl.push_back(mk(6'b001000, 8'h00, 8'h00, 8'h00, 1, 8'h30, 8'h11, 8'h07, 1, 3'b000, 8'h30));
        tbl.push_back(mk(6'b000010, 8'h00, 8'h00, 8'h00, 0, 8'h30, 8'h07, 8'h00, 0, 3'b000, 8'h30));
        tbl.push_back(mk(6'b000100, 8'h00, 8'h00, 8'h5A, 0, 8'h30, 8'h07, 8'h5A, 1, 3'b000, 8'h30));
        tbl.push_back(mk(6'b000110, 8'h00, 8'h00, 8'h6B, 0, 8'h30, 8'h5A, 8'h6B, 1, 3'b000, 8'h30));
        tbl.push_back(mk(6'b010100, 8'h50, 8'h60, 8'h99, 1, 8'h60, 8'h5A, 8'h50, 2, 3'b000, 8'h50));
        tbl.push_back(mk(6'b001000, 8'h00, 8'h00, 8'h00, 1, 8'h50, 8'h5A, 8'h6B, 1, 3'b000, 8'h50));
        tbl.push_back(mk(6'b000100, 8'h00, 8'h00, 8'h01, 0, 8'h50, 8'h5A, 8'h01, 2, 3'b000, 8'h50));
        tbl.push_back(mk(6'b000100, 8'h00, 8'h00, 8'h02, 0, 8'h50, 8'h5A, 8'h02, 3, 3'b000, 8'h50));
        tbl.push_back(mk(6'b000100, 8'h00, 8'h00, 8'h03, 0, 8'h50, 8'h5A, 8'h03, 4, 3'b000, 8'h50));
        tbl.push_back(mk(6'b010000, 8'h70, 8'h80, 8'h00, 0, 8'h50, 8'h5A, 8'h03, 4, 3'b100, 8'h50));
        tbl.push_back(mk(6'b000101, 8'h00, 8'h00, 8'h04, 0, 8'h50, 8'h5A, 8'h03, 4, 3'b100, 8'h50));
        tbl.push_back(mk(6'b000001, 8'h00, 8'h00, 8'h00, 0, 8'h50, 8'h5A, 8'h03, 4, 3'b000, 8'h50));
        tbl.push_back(mk(6'b100000, 8'h77, 8'h00, 8'h00, 0, 8'h50, 8'h5A, 8'h03, 4, 3'b100, 8'h50));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ctl, tbl[i].pc, tbl[i].tg, tbl[i].di);
            chk($sformatf("vec%0d pc_load", i), pc_load, tbl[i].x_ld);
            chk($sformatf("vec%0d pc_out", i), pc_out, tbl[i].x_pc);
            chk($sformatf("vec%0d data_out", i), data_out, tbl[i].x_do);
            chk($sformatf("vec%0d top", i), top, tbl[i].x_top);
            chk($sformatf("vec%0d count", i), count, tbl[i].x_cnt);
            chk($sformatf("vec%0d full", i), full, tbl[i].x_cnt == 3'd4);
            chk($sformatf("vec%0d empty", i), empty, tbl[i].x_cnt == 3'd0);
            chk($sformatf("vec%0d ovf", i), ovf, tbl[i].x_flg[2]);
            chk($sformatf("vec%0d unf", i), unf, tbl[i].x_flg[1]);
            chk($sformatf("vec%0d in_isr", i), in_isr, tbl[i].x_flg[0]);
            chk($sformatf("vec%0d lnk", i), lnk, tbl[i].x_lnk);
        end

        // Reset asserted mid-operation, checked before any further clock edge.
        do_reset();
        drive(6'b100000, 8'h12, 8'h00, 8'h00);
        drive(6'b010000, 8'h13, 8'h44, 8'h00);
        chk("pre-rst pc_load", pc_load, 1);
        chk("pre-rst count", count, 2);
        chk("pre-rst in_isr", in_isr, 1);
        {eint, call, ret, push, pop, clr_err} = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("async pc_load", pc_load, 0);
        chk("async count", count, 0);
        chk("async in_isr", in_isr, 0);
        chk("async top", top, 0);
        chk("async pc_out", pc_out, 0);
        chk("async lnk", lnk, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 800; i++) begin
            drive({($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0)},
                  8'($urandom), 8'($urandom), 8'($urandom));
            cmp_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
